// File: rtl/adc_frame_packer.sv
// Serializes two-channel ADC samples into checksummed UART byte frames through a small sample FIFO.
// Optional ADC_FRAME_SEQ_EN inserts a wrapping sequence byte after SYNC.
module adc_frame_packer #(
  parameter int unsigned SAMPLE_W = 14,
  parameter int unsigned FIFO_W   = 2,
  parameter logic [7:0]  SYNC     = 8'hA5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                end_conv,
  input  logic [SAMPLE_W-1:0] ch0_in,
  input  logic [SAMPLE_W-1:0] ch1_in,
  input  logic                tx_full,
  output logic                wr_uart,
  output logic [7:0]          w_data,
  output logic                busy,
  output logic [7:0]          drop_cnt
);

  localparam int unsigned DEPTH  = 2 ** FIFO_W;
  localparam int unsigned PAIR_W = 2 * SAMPLE_W;
  localparam int unsigned CNT_W  = FIFO_W + 1;
  localparam int unsigned IDX_W  = 3;
`ifdef ADC_FRAME_SEQ_EN
  localparam int unsigned HDR_LEN = 2;
`else
  localparam int unsigned HDR_LEN = 1;
`endif
  localparam int unsigned LAST_IDX = HDR_LEN + 4;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SEND = 2'd2} state_t;

  state_t              state_q, state_d;
  logic                end_conv_q;
  logic                capture_c, push_c, pop_c, send_c, drop_c, full_c, last_c;
  logic [PAIR_W-1:0]   mem [DEPTH];
  logic [FIFO_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PAIR_W-1:0]   frame_q;
  logic [IDX_W-1:0]    idx_q;
  logic [7:0]          csum_q, byte_c;
  logic [SAMPLE_W-1:0] f_ch0, f_ch1;

  assign capture_c = end_conv & ~end_conv_q;
  assign full_c    = (count_q == CNT_W'(DEPTH));
  assign push_c    = capture_c & enable & (~full_c | pop_c);
  assign drop_c    = capture_c & enable & full_c & ~pop_c;
  assign last_c    = (idx_q == IDX_W'(LAST_IDX));
  assign f_ch0     = frame_q[SAMPLE_W-1:0];
  assign f_ch1     = frame_q[PAIR_W-1:SAMPLE_W];

  // Next-state logic; IDLE waits for UART room so queued samples stay in the FIFO
  always_comb begin
    state_d = state_q;
    pop_c   = 1'b0;
    send_c  = 1'b0;
    case (state_q)
      IDLE: if (count_q != '0 && !tx_full) state_d = LOAD;
      LOAD: begin
        pop_c   = 1'b1;
        state_d = SEND;
      end
      SEND: if (!tx_full) begin
        send_c = 1'b1;
        if (last_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push_c && !pop_c)      count_d = count_q + CNT_W'(1);
    else if (!push_c && pop_c) count_d = count_q - CNT_W'(1);
  end

`ifdef ADC_FRAME_SEQ_EN
  logic [7:0] seq_q;

  // Frame sequence number, advanced on each frame's final byte
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              seq_q <= 8'd0;
    else if (send_c && last_c) seq_q <= seq_q + 8'd1;
  end
`endif

  // Byte selected by the current frame index
  always_comb begin
    byte_c = SYNC;
    case (idx_q)
`ifdef ADC_FRAME_SEQ_EN
      IDX_W'(1):           byte_c = seq_q;
`endif
      IDX_W'(HDR_LEN):     byte_c = 8'(f_ch0 >> 8);
      IDX_W'(HDR_LEN + 1): byte_c = f_ch0[7:0];
      IDX_W'(HDR_LEN + 2): byte_c = 8'(f_ch1 >> 8);
      IDX_W'(HDR_LEN + 3): byte_c = f_ch1[7:0];
      IDX_W'(LAST_IDX):    byte_c = csum_q;
      default:             byte_c = SYNC;
    endcase
  end

  assign wr_uart = send_c;
  assign w_data  = send_c ? byte_c : 8'd0;

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr_q] <= {ch1_in, ch0_in};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      busy       <= 1'b0;
      end_conv_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt   <= 8'd0;
    end else begin
      state_q    <= state_d;
      busy       <= (state_d != IDLE) || (count_d != '0);
      end_conv_q <= end_conv;
      count_q    <= count_d;
      if (push_c) wr_ptr_q <= wr_ptr_q + FIFO_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + FIFO_W'(1);
      if (drop_c && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Frame register, byte index and running checksum over all bytes between SYNC and the checksum
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_q <= '0;
      idx_q   <= '0;
      csum_q  <= 8'd0;
    end else if (pop_c) begin
      frame_q <= mem[rd_ptr_q];
      idx_q   <= '0;
      csum_q  <= 8'd0;
    end else if (send_c) begin
      idx_q <= idx_q + IDX_W'(1);
      if (idx_q != '0 && !last_c) csum_q <= csum_q ^ byte_c;
    end
  end

endmodule

// File: tb/tb_adc_frame_packer.sv
// Self-checking bench for adc_frame_packer: randomized samples against a byte-stream reference model.
module tb_adc_frame_packer;

  localparam int unsigned SW = 14;
`ifdef ADC_FRAME_SEQ_EN
  localparam int FLEN = 7;
`else
  localparam int FLEN = 6;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b1;
  logic          end_conv = 1'b0;
  logic [SW-1:0] ch0 = '0;
  logic [SW-1:0] ch1 = '0;
  logic          tx_full = 1'b0;
  logic          wr_uart;
  logic [7:0]    w_data;
  logic          busy;
  logic [7:0]    drop_cnt;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int viol = 0;
  int exp_seq = 0;
  int exp_drop = 0;
  logic [7:0] got_b[$];
  int         got_t[$];
  logic [7:0] exp_b[$];

  adc_frame_packer #(.SAMPLE_W(SW), .FIFO_W(2), .SYNC(8'hA5)) dut (
    .clk(clk), .reset(reset), .enable(enable), .end_conv(end_conv),
    .ch0_in(ch0), .ch1_in(ch1), .tx_full(tx_full),
    .wr_uart(wr_uart), .w_data(w_data), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (wr_uart === 1'b1) begin
      got_b.push_back(w_data);
      got_t.push_back(cyc);
      if (tx_full === 1'b1) viol++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference frame: SYNC, [seq], ch0 hi/lo, ch1 hi/lo, XOR of the bytes between
  function automatic void add_frame(input int c0, input int c1);
    int b[$];
    int cs;
`ifdef ADC_FRAME_SEQ_EN
    b.push_back(exp_seq);
    exp_seq = (exp_seq + 1) % 256;
`endif
    b.push_back(c0 / 256); b.push_back(c0 % 256);
    b.push_back(c1 / 256); b.push_back(c1 % 256);
    cs = 0;
    foreach (b[i]) cs = cs ^ b[i];
    exp_b.push_back(8'hA5);
    foreach (b[i]) exp_b.push_back(8'(b[i]));
    exp_b.push_back(8'(cs));
  endfunction

  function automatic void clear_streams();
    got_b.delete(); got_t.delete(); exp_b.delete();
  endfunction

  task automatic capture(input logic [SW-1:0] a, input logic [SW-1:0] b, output int n);
    @(posedge clk); #1;
    ch0 = a; ch1 = b; end_conv = 1'b1; n = cyc;
    @(posedge clk); #1;
    end_conv = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    repeat (3) @(posedge clk);
    for (int i = 0; i < 20000 && busy !== 1'b0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    if (busy !== 1'b0) begin
      tests++; fails++;
      $display("FAIL %s_timeout: busy=%b, required 0 within budget", name, busy);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++; if (wr_uart !== 1'b0) begin fails++; $display("FAIL reset_wr_uart: got %b required 0", wr_uart); end
    tests++; if (w_data !== 8'd0) begin fails++; $display("FAIL reset_w_data: got %h required 00", w_data); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b required 0", busy); end
    tests++; if (drop_cnt !== 8'd0) begin fails++; $display("FAIL reset_drop_cnt: got %0d required 0", drop_cnt); end
    @(posedge clk); #1 reset = 1'b1;
  endtask

  task automatic test_single();
    int n;
    clear_streams();
    capture(14'h2ABC, 14'h0123, n);
    add_frame(32'h2ABC, 32'h0123);
    for (int i = 0; i < FLEN + 6; i++) begin
      @(negedge clk);
      if (cyc == n + 1) begin
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy_early: got %b required 1", busy); end
      end
      if (cyc == n + FLEN + 3) begin
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_after: got %b required 0", busy); end
      end
    end
    wait_idle("single");
    tests++;
    if (got_b.size() != exp_b.size()) begin fails++; $display("FAIL single_len: got %0d bytes required %0d", got_b.size(), exp_b.size()); end
    foreach (exp_b[i]) if (i < got_b.size()) begin
      tests++; if (got_b[i] !== exp_b[i]) begin fails++; $display("FAIL single_byte%0d: got %h required %h", i, got_b[i], exp_b[i]); end
    end
    if (got_b.size() == FLEN) begin
      tests++; if (got_b[0] !== 8'hA5) begin fails++; $display("FAIL single_sync: got %h required a5", got_b[0]); end
      tests++; if (got_b[FLEN-1] !== 8'hB4) begin fails++; $display("FAIL single_csum: got %h required b4", got_b[FLEN-1]); end
      tests++; if (got_t[0] != n + 3) begin fails++; $display("FAIL single_first_lat: got cycle %0d required %0d", got_t[0], n + 3); end
      tests++; if (got_t[FLEN-1] != n + FLEN + 2) begin fails++; $display("FAIL single_last_lat: got cycle %0d required %0d", got_t[FLEN-1], n + FLEN + 2); end
    end
  endtask

  task automatic test_held();
    int a, b;
    clear_streams();
    a = $urandom_range(0, 16383); b = $urandom_range(0, 16383);
    @(posedge clk); #1;
    ch0 = SW'(a); ch1 = SW'(b); end_conv = 1'b1;
    repeat (100) @(posedge clk);
    #1 end_conv = 1'b0;
    add_frame(a, b);
    wait_idle("held");
    tests++;
    if (got_b.size() != exp_b.size()) begin fails++; $display("FAIL held_len: got %0d bytes required %0d", got_b.size(), exp_b.size()); end
    foreach (exp_b[i]) if (i < got_b.size()) begin
      tests++; if (got_b[i] !== exp_b[i]) begin fails++; $display("FAIL held_byte%0d: got %h required %h", i, got_b[i], exp_b[i]); end
    end
  endtask

  task automatic test_enable();
    int n;
    clear_streams();
    enable = 1'b0;
    capture(SW'($urandom), SW'($urandom), n);
    repeat (15) @(negedge clk);
    enable = 1'b1;
    tests++; if (got_b.size() != 0) begin fails++; $display("FAIL enable_off_bytes: got %0d bytes required 0", got_b.size()); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL enable_off_busy: got %b required 0", busy); end
  endtask

  task automatic test_stall();
    int n, a, b;
    clear_streams();
    a = $urandom_range(0, 16383); b = $urandom_range(0, 16383);
    capture(SW'(a), SW'(b), n);
    add_frame(a, b);
    repeat (5) @(posedge clk);
    #1 tx_full = 1'b1;
    repeat (20) @(posedge clk);
    #1 tx_full = 1'b0;
    wait_idle("stall");
    tests++;
    if (got_b.size() != exp_b.size()) begin fails++; $display("FAIL stall_len: got %0d bytes required %0d", got_b.size(), exp_b.size()); end
    foreach (exp_b[i]) if (i < got_b.size()) begin
      tests++; if (got_b[i] !== exp_b[i]) begin fails++; $display("FAIL stall_byte%0d: got %h required %h", i, got_b[i], exp_b[i]); end
    end
    if (got_t.size() == FLEN) begin
      tests++; if (got_t[2] != n + 5) begin fails++; $display("FAIL stall_byte2_time: got cycle %0d required %0d", got_t[2], n + 5); end
      tests++; if (got_t[3] != n + 26) begin fails++; $display("FAIL stall_byte3_time: got cycle %0d required %0d", got_t[3], n + 26); end
    end
    tests++; if (viol != 0) begin fails++; $display("FAIL stall_strobe_while_full: got %0d strobes required 0", viol); end
  endtask

  task automatic test_back_to_back();
    int n, a, b;
    clear_streams();
    for (int k = 0; k < 3; k++) begin
      a = $urandom_range(0, 16383); b = $urandom_range(0, 16383);
      capture(SW'(a), SW'(b), n);
      add_frame(a, b);
    end
    wait_idle("b2b");
    tests++;
    if (got_b.size() != exp_b.size()) begin fails++; $display("FAIL b2b_len: got %0d bytes required %0d", got_b.size(), exp_b.size()); end
    foreach (exp_b[i]) if (i < got_b.size()) begin
      tests++; if (got_b[i] !== exp_b[i]) begin fails++; $display("FAIL b2b_byte%0d: got %h required %h", i, got_b[i], exp_b[i]); end
    end
    if (got_t.size() == 3 * FLEN) begin
      tests++; if (got_t[FLEN] - got_t[0] != FLEN + 2) begin fails++; $display("FAIL b2b_interval: got %0d cycles required %0d", got_t[FLEN] - got_t[0], FLEN + 2); end
      tests++; if (got_t[FLEN-1] - got_t[0] != FLEN - 1) begin fails++; $display("FAIL b2b_contiguous: got %0d cycles required %0d", got_t[FLEN-1] - got_t[0], FLEN - 1); end
    end
  endtask

  task automatic test_overflow();
    int n, a, b;
    clear_streams();
    @(posedge clk); #1 tx_full = 1'b1;
    for (int k = 0; k < 6; k++) begin
      a = $urandom_range(0, 16383); b = $urandom_range(0, 16383);
      capture(SW'(a), SW'(b), n);
      if (k < 4) add_frame(a, b);
      else exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
    end
    repeat (2) @(negedge clk);
    tests++; if (drop_cnt !== 8'(exp_drop)) begin fails++; $display("FAIL ovf_drop_cnt: got %0d required %0d", drop_cnt, exp_drop); end
    tests++; if (got_b.size() != 0) begin fails++; $display("FAIL ovf_no_strobe: got %0d bytes required 0", got_b.size()); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL ovf_busy: got %b required 1", busy); end
    @(posedge clk); #1 tx_full = 1'b0;
    wait_idle("ovf");
    tests++;
    if (got_b.size() != exp_b.size()) begin fails++; $display("FAIL ovf_len: got %0d bytes required %0d", got_b.size(), exp_b.size()); end
    foreach (exp_b[i]) if (i < got_b.size()) begin
      tests++; if (got_b[i] !== exp_b[i]) begin fails++; $display("FAIL ovf_byte%0d: got %h required %h", i, got_b[i], exp_b[i]); end
    end
    clear_streams();
    @(posedge clk); #1 tx_full = 1'b1;
    for (int k = 0; k < 304; k++) begin
      a = $urandom_range(0, 16383); b = $urandom_range(0, 16383);
      capture(SW'(a), SW'(b), n);
      if (k < 4) add_frame(a, b);
      else exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
    end
    @(negedge clk);
    tests++; if (drop_cnt !== 8'(exp_drop)) begin fails++; $display("FAIL ovf_saturate: got %0d required %0d", drop_cnt, exp_drop); end
    @(posedge clk); #1 tx_full = 1'b0;
    wait_idle("ovf_sat");
    tests++;
    if (got_b.size() != exp_b.size()) begin fails++; $display("FAIL ovf_sat_len: got %0d bytes required %0d", got_b.size(), exp_b.size()); end
    foreach (exp_b[i]) if (i < got_b.size()) begin
      tests++; if (got_b[i] !== exp_b[i]) begin fails++; $display("FAIL ovf_sat_byte%0d: got %h required %h", i, got_b[i], exp_b[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int n, m, a, b;
    clear_streams();
    capture(SW'($urandom), SW'($urandom), n);
    capture(SW'($urandom), SW'($urandom), m);
    repeat (3) @(posedge clk);
    tests++; if (got_b.size() != 3) begin fails++; $display("FAIL rmid_partial: got %0d bytes before reset required 3", got_b.size()); end
    #1 reset = 1'b0;
    #1;
    tests++; if (wr_uart !== 1'b0) begin fails++; $display("FAIL rmid_wr_uart: got %b required 0", wr_uart); end
    tests++; if (w_data !== 8'd0) begin fails++; $display("FAIL rmid_w_data: got %h required 00", w_data); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_busy: got %b required 0", busy); end
    tests++; if (drop_cnt !== 8'd0) begin fails++; $display("FAIL rmid_drop_cnt: got %0d required 0", drop_cnt); end
    @(posedge clk); #1 reset = 1'b1;
    exp_seq = 0; exp_drop = 0;
    clear_streams();
    a = $urandom_range(0, 16383); b = $urandom_range(0, 16383);
    capture(SW'(a), SW'(b), n);
    add_frame(a, b);
    wait_idle("rmid");
    tests++;
    if (got_b.size() != exp_b.size()) begin fails++; $display("FAIL rmid_len: got %0d bytes required %0d", got_b.size(), exp_b.size()); end
    foreach (exp_b[i]) if (i < got_b.size()) begin
      tests++; if (got_b[i] !== exp_b[i]) begin fails++; $display("FAIL rmid_byte%0d: got %h required %h", i, got_b[i], exp_b[i]); end
    end
  endtask

  task automatic test_random();
    int k, a, b;
    clear_streams();
    k = 0;
    for (int c = 0; c < 20 * 40; c++) begin
      @(posedge clk); #1;
      tx_full = ($urandom_range(0, 9) < 3);
      if (c % 40 == 0 && k < 20) begin
        a = $urandom_range(0, 16383); b = $urandom_range(0, 16383);
        ch0 = SW'(a); ch1 = SW'(b); end_conv = 1'b1;
        add_frame(a, b);
        k++;
      end else begin
        end_conv = 1'b0;
      end
    end
    @(posedge clk); #1 tx_full = 1'b0; end_conv = 1'b0;
    wait_idle("rand");
    tests++;
    if (got_b.size() != exp_b.size()) begin fails++; $display("FAIL rand_len: got %0d bytes required %0d", got_b.size(), exp_b.size()); end
    foreach (exp_b[i]) if (i < got_b.size()) begin
      tests++; if (got_b[i] !== exp_b[i]) begin fails++; $display("FAIL rand_byte%0d: got %h required %h", i, got_b[i], exp_b[i]); end
    end
    tests++; if (viol != 0) begin fails++; $display("FAIL rand_strobe_while_full: got %0d strobes required 0", viol); end
    tests++; if (drop_cnt !== 8'(exp_drop)) begin fails++; $display("FAIL rand_drop_cnt: got %0d required %0d", drop_cnt, exp_drop); end
  endtask

`ifdef ADC_FRAME_SEQ_EN
  task automatic test_seq_wrap();
    int n, a, b;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    exp_seq = 0; exp_drop = 0;
    clear_streams();
    for (int k = 0; k < 257; k++) begin
      a = $urandom_range(0, 16383); b = $urandom_range(0, 16383);
      capture(SW'(a), SW'(b), n);
      add_frame(a, b);
      repeat (10) @(posedge clk);
    end
    wait_idle("seq");
    tests++;
    if (got_b.size() != exp_b.size()) begin fails++; $display("FAIL seq_len: got %0d bytes required %0d", got_b.size(), exp_b.size()); end
    foreach (exp_b[i]) if (i < got_b.size()) begin
      tests++; if (got_b[i] !== exp_b[i]) begin fails++; $display("FAIL seq_byte%0d: got %h required %h", i, got_b[i], exp_b[i]); end
    end
    if (got_b.size() == 257 * FLEN) begin
      tests++; if (got_b[1 + 255 * FLEN] !== 8'hFF) begin fails++; $display("FAIL seq_ff: got %h required ff", got_b[1 + 255 * FLEN]); end
      tests++; if (got_b[1 + 256 * FLEN] !== 8'h00) begin fails++; $display("FAIL seq_wrap: got %h required 00", got_b[1 + 256 * FLEN]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_held();
    test_enable();
    test_stall();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_random();
`ifdef ADC_FRAME_SEQ_EN
    test_seq_wrap();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
